// File: rtl/sobel_pkg.sv
// Shared encodings and width helpers for the streaming Sobel edge detector.
package sobel_pkg;

  typedef enum logic [1:0] {
    MAG    = 2'd0,
    ABS_GX = 2'd1,
    ABS_GY = 2'd2,
    THRESH = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic int grad_w(input int pix_w);
    return pix_w + 3;
  endfunction

  function automatic int mag_w(input int pix_w);
    return pix_w + 4;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two-line pixel store: combinational read at the column, shift-down write on accept.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int MAX_W = 640,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] top,
  output logic [PIX_W-1:0] mid
);

  logic [PIX_W-1:0] lb0_q [MAX_W];
  logic [PIX_W-1:0] lb1_q [MAX_W];

  assign top = lb1_q[addr];
  assign mid = lb0_q[addr];

  // Contents are deliberately unreset; stale lines never reach a live window.
  always_ff @(posedge clk) begin
    if (we) begin
      lb1_q[addr] <= lb0_q[addr];
      lb0_q[addr] <= din;
    end
  end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel: line buffers, window register, gradient stage, mode/output stage.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int MAX_W = 640,
  parameter int DIM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] W,
  input  logic [DIM_W-1:0] H,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] thresh,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pix,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pix,
  output logic             out_last,
  output logic [DIM_W-1:0] out_col,
  output logic [DIM_W-1:0] out_row,
  output logic             done,
  output logic             err
);

  localparam int GRAD_W = grad_w(PIX_W);
  localparam int MAG_W  = mag_w(PIX_W);
  localparam int AW     = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  state_e                    state_q, state_d;
  mode_e                     mode_q, mode_d;
  logic [DIM_W-1:0]          w_q, w_d, h_q, h_d, in_col_q, in_col_d, in_row_q, in_row_d;
  logic [PIX_W-1:0]          thresh_q, thresh_d;
  logic                      err_q, err_d, done_q, done_d;
  logic [PIX_W-1:0]          win_q [3][3];
  logic [PIX_W-1:0]          win_d [3][3];
  logic                      s0_valid_q, s0_valid_d, s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
  logic [DIM_W-1:0]          s0_col_q, s0_col_d, s0_row_q, s0_row_d;
  logic [DIM_W-1:0]          s1_col_q, s1_col_d, s1_row_q, s1_row_d;
  logic signed [GRAD_W-1:0]  gx_q, gx_d, gy_q, gy_d;
  logic [PIX_W-1:0]          out_pix_q, out_pix_d;
  logic                      out_last_q, out_last_d;
  logic [DIM_W-1:0]          out_col_q, out_col_d, out_row_q, out_row_d;

  logic                      adv, accept, live, col_end, row_end, dims_ok, pipe_empty;
  logic [PIX_W-1:0]          lb_top, lb_mid, res_s;
  logic [GRAD_W-1:0]         ax_s, ay_s;
  logic [MAG_W-1:0]          mag_s;

  function automatic logic signed [GRAD_W-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({3'b000, p});
  endfunction

  function automatic logic [PIX_W-1:0] sat(input logic [MAG_W-1:0] x);
    logic [MAG_W-1:0] lim;
    lim = {{(MAG_W-PIX_W){1'b0}}, {PIX_W{1'b1}}};
    return (x > lim) ? {PIX_W{1'b1}} : x[PIX_W-1:0];
  endfunction

  assign adv        = !(out_valid_q && !out_ready);
  assign in_ready   = (state_q == RUN) && adv;
  assign accept     = in_valid && in_ready;
  assign live       = (in_row_q >= DIM_W'(2)) && (in_col_q >= DIM_W'(2));
  assign col_end    = (in_col_q == w_q - DIM_W'(1));
  assign row_end    = (in_row_q == h_q - DIM_W'(1));
  assign dims_ok    = (W >= DIM_W'(3)) && (W <= DIM_W'(MAX_W)) && (H >= DIM_W'(3));
  assign pipe_empty = !s0_valid_q && !s1_valid_q && (!out_valid_q || out_ready);

  sobel_line_buffer #(.PIX_W(PIX_W), .MAX_W(MAX_W), .AW(AW)) u_lb (
    .clk  (clk),
    .we   (accept),
    .addr (in_col_q[AW-1:0]),
    .din  (in_pix),
    .top  (lb_top),
    .mid  (lb_mid)
  );

  // Output-stage arithmetic: absolute gradients, magnitude and mode select.
  always_comb begin
    ax_s  = gx_q[GRAD_W-1] ? GRAD_W'(-gx_q) : GRAD_W'(gx_q);
    ay_s  = gy_q[GRAD_W-1] ? GRAD_W'(-gy_q) : GRAD_W'(gy_q);
    mag_s = {1'b0, ax_s} + {1'b0, ay_s};
    case (mode_q)
      MAG:     res_s = sat(mag_s);
      ABS_GX:  res_s = sat({1'b0, ax_s});
      ABS_GY:  res_s = sat({1'b0, ay_s});
      THRESH:  res_s = (sat(mag_s) >= thresh_q) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
      default: res_s = sat(mag_s);
    endcase
  end

  // Next-state: FSM, raster counters and the three pipeline stages.
  always_comb begin
    state_d = state_q;     mode_d = mode_q;         w_d = w_q;           h_d = h_q;
    thresh_d = thresh_q;   err_d = err_q;           done_d = 1'b0;
    in_col_d = in_col_q;   in_row_d = in_row_q;     win_d = win_q;
    s0_valid_d = s0_valid_q; s0_col_d = s0_col_q;   s0_row_d = s0_row_q;
    s1_valid_d = s1_valid_q; s1_col_d = s1_col_q;   s1_row_d = s1_row_q;
    gx_d = gx_q;           gy_d = gy_q;             out_valid_d = out_valid_q;
    out_pix_d = out_pix_q; out_last_d = out_last_q; out_col_d = out_col_q;
    out_row_d = out_row_q;

    if (accept) begin
      in_col_d = col_end ? '0 : in_col_q + DIM_W'(1);
      in_row_d = col_end ? in_row_q + DIM_W'(1) : in_row_q;
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb_top;
      win_d[1][2] = lb_mid;
      win_d[2][2] = in_pix;
      s0_col_d    = in_col_q - DIM_W'(2);
      s0_row_d    = in_row_q - DIM_W'(2);
    end else begin
      in_col_d = in_col_q;
    end

    if (adv) begin
      s0_valid_d  = accept && live;
      s1_valid_d  = s0_valid_q;
      out_valid_d = s1_valid_q;
      if (s0_valid_q) begin
        gx_d = (ext(win_q[0][2]) + ext(win_q[1][2]) + ext(win_q[1][2]) + ext(win_q[2][2]))
             - (ext(win_q[0][0]) + ext(win_q[1][0]) + ext(win_q[1][0]) + ext(win_q[2][0]));
        gy_d = (ext(win_q[2][0]) + ext(win_q[2][1]) + ext(win_q[2][1]) + ext(win_q[2][2]))
             - (ext(win_q[0][0]) + ext(win_q[0][1]) + ext(win_q[0][1]) + ext(win_q[0][2]));
        s1_col_d = s0_col_q;
        s1_row_d = s0_row_q;
      end else begin
        gx_d = gx_q;
      end
      if (s1_valid_q) begin
        out_pix_d  = res_s;
        out_col_d  = s1_col_q;
        out_row_d  = s1_row_q;
        out_last_d = (s1_col_q == w_q - DIM_W'(3)) && (s1_row_q == h_q - DIM_W'(3));
      end else begin
        out_pix_d = out_pix_q;
      end
    end else begin
      s0_valid_d = s0_valid_q;
    end

    case (state_q)
      IDLE: begin
        if (start && dims_ok) begin
          state_d  = RUN;      w_d = W;   h_d = H;
          mode_d   = mode_e'(mode);       thresh_d = thresh;
          in_col_d = '0;       in_row_d = '0;
          out_col_d = '0;      out_row_d = '0;
          err_d    = 1'b0;
        end else if (start) begin
          err_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN:     state_d = (accept && col_end && row_end) ? DRAIN : RUN;
      DRAIN: begin
        if (pipe_empty) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and pipeline registers; async reset drops any tokens in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;   mode_q <= MAG;    w_q <= '0;   h_q <= '0;  thresh_q <= '0;
      err_q <= 1'b0;     done_q <= 1'b0;   in_col_q <= '0;  in_row_q <= '0;
      win_q <= '{default: '0};
      s0_valid_q <= 1'b0; s0_col_q <= '0;  s0_row_q <= '0;
      s1_valid_q <= 1'b0; s1_col_q <= '0;  s1_row_q <= '0;
      gx_q <= '0;        gy_q <= '0;       out_valid_q <= 1'b0;
      out_pix_q <= '0;   out_last_q <= 1'b0; out_col_q <= '0;  out_row_q <= '0;
    end else begin
      state_q <= state_d; mode_q <= mode_d; w_q <= w_d;   h_q <= h_d;  thresh_q <= thresh_d;
      err_q <= err_d;    done_q <= done_d; in_col_q <= in_col_d;  in_row_q <= in_row_d;
      win_q <= win_d;
      s0_valid_q <= s0_valid_d; s0_col_q <= s0_col_d; s0_row_q <= s0_row_d;
      s1_valid_q <= s1_valid_d; s1_col_q <= s1_col_d; s1_row_q <= s1_row_d;
      gx_q <= gx_d;      gy_q <= gy_d;     out_valid_q <= out_valid_d;
      out_pix_q <= out_pix_d; out_last_q <= out_last_d; out_col_q <= out_col_d;
      out_row_q <= out_row_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pix   = out_pix_q;
  assign out_last  = out_last_q;
  assign out_col   = out_col_q;
  assign out_row   = out_row_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sobel_stream.sv
// Directed bench for sobel_stream with a reference-model scoreboard.
module tb_sobel_stream;

  logic        clk, rst, start, in_valid, in_ready, out_valid, out_ready, out_last, done, err;
  logic [15:0] w_in, h_in, out_col, out_row;
  logic [1:0]  mode_in;
  logic [7:0]  thresh_in, in_pix, out_pix;

  sobel_stream #(.PIX_W(8), .MAX_W(640), .DIM_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .W(w_in), .H(h_in), .mode(mode_in),
    .thresh(thresh_in), .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
    .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix), .out_last(out_last),
    .out_col(out_col), .out_row(out_row), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pix;
    logic [15:0] col;
    logic [15:0] row;
    logic        last;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] img [0:15][0:15];
  int vectors = 0, miscompares = 0;
  int fw = 0, fh = 0, fmode = 0, fthr = 0, cur_idx = 0, n_out = 0;
  bit exp_done = 1'b0, hold_chk = 1'b0;
  logic [7:0]  h_pix;
  logic [15:0] h_col, h_row;
  logic        h_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int px(int r, int c);
    return int'(img[r][c]);
  endfunction

  function automatic int sat8(int x);
    return (x > 255) ? 255 : x;
  endfunction

  task automatic push_exp(int r, int c);
    int gx, gy, ax, ay, s;
    exp_t e;
    gx = (px(r-2,c) + 2*px(r-1,c) + px(r,c)) - (px(r-2,c-2) + 2*px(r-1,c-2) + px(r,c-2));
    gy = (px(r,c-2) + 2*px(r,c-1) + px(r,c)) - (px(r-2,c-2) + 2*px(r-2,c-1) + px(r-2,c));
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    s  = sat8(ax + ay);
    case (fmode)
      1:       e.pix = 8'(sat8(ax));
      2:       e.pix = 8'(sat8(ay));
      3:       e.pix = (s >= fthr) ? 8'd255 : 8'd0;
      default: e.pix = 8'(s);
    endcase
    e.col  = 16'(c - 2);
    e.row  = 16'(r - 2);
    e.last = (c == fw - 1) && (r == fh - 1);
    sb.push_back(e);
  endtask

  // One clock: sample handshakes at the falling edge, then return just after the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (hold_chk) begin
      check("hold_valid", out_valid, 1);
      check("hold_pix", out_pix, h_pix);
      check("hold_col", out_col, h_col);
      check("hold_row", out_row, h_row);
      check("hold_last", out_last, h_last);
    end
    check("done", done, exp_done);
    exp_done = 1'b0;
    if (in_valid && in_ready) begin
      if (cur_idx / fw >= 2 && cur_idx % fw >= 2) push_exp(cur_idx / fw, cur_idx % fw);
      cur_idx++;
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", out_valid, 0);
      end else begin
        e = sb.pop_front();
        n_out++;
        check("out_pix", out_pix, e.pix);
        check("out_col", out_col, e.col);
        check("out_row", out_row, e.row);
        check("out_last", out_last, e.last);
        exp_done = e.last;
      end
    end
    hold_chk = out_valid && !out_ready;
    h_pix = out_pix; h_col = out_col; h_row = out_row; h_last = out_last;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(int w, int h, int md, int thr);
    fw = w; fh = h; fmode = md; fthr = thr; cur_idx = 0; n_out = 0;
    w_in = 16'(w); h_in = 16'(h); mode_in = 2'(md); thresh_in = 8'(thr);
    in_valid = 1'b0; out_ready = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_frame(int w, int h, int md, int thr, bit bp);
    int guard = 0;
    do_start(w, h, md, thr);
    check("err_clear", err, 0);
    while ((cur_idx < w*h || sb.size() != 0) && guard < 4000) begin
      in_valid = (cur_idx < w*h) && (!bp || $urandom_range(0, 3) != 0);
      if (cur_idx < w*h) in_pix = img[cur_idx / w][cur_idx % w];
      out_ready = !bp || ($urandom_range(0, 2) != 0);
      cycle();
      guard++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    check("timeout", guard < 4000, 1);
    check("out_count", n_out, (w-2)*(h-2));
  endtask

  task automatic fill_img(int kind, int w, int h);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        case (kind)
          0:       img[r][c] = 8'(10*c);
          1:       img[r][c] = (c >= 2) ? 8'd255 : 8'd0;
          2:       img[r][c] = 8'd128;
          default: img[r][c] = 8'($urandom_range(0, 255));
        endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_pix = 8'd0; out_ready = 1'b0;
    w_in = 16'd0; h_in = 16'd0; mode_in = 2'd0; thresh_in = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pix", out_pix, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    // Bad dimensions
    do_start(2, 3, 0, 0);
    check("bad_w2_err", err, 1);
    check("bad_w2_ready", in_ready, 0);
    cycle();
    check("bad_w2_idle", in_ready, 0);
    do_start(641, 3, 0, 0);
    check("bad_wmax_err", err, 1);

    fill_img(0, 5, 3);
    run_frame(5, 3, 0, 0, 1'b0);

    fill_img(1, 4, 4);
    run_frame(4, 4, 0, 0, 1'b0);
    run_frame(4, 4, 2, 0, 1'b0);
    run_frame(4, 4, 3, 200, 1'b0);

    fill_img(2, 8, 6);
    run_frame(8, 6, 0, 0, 1'b0);

    fill_img(3, 6, 5);
    run_frame(6, 5, 0, 0, 1'b1);
    run_frame(6, 5, 3, 100, 1'b1);

    // Reset in the middle of a frame
    fill_img(3, 6, 5);
    do_start(6, 5, 0, 0);
    while (cur_idx < 10) begin
      in_valid = 1'b1;
      in_pix = img[cur_idx / 6][cur_idx % 6];
      cycle();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_pix", out_pix, 0);
    check("mid_rst_out_col", out_col, 0);
    check("mid_rst_out_row", out_row, 0);
    check("mid_rst_out_last", out_last, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_done", done, 0);
    sb.delete();
    hold_chk = 1'b0; exp_done = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_frame(6, 5, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
